// File: rtl/core_timer_pkg.sv
// Shared constants for the KRV machine timer: register byte offsets,
// reset value of mtimecmp and the ctrl field layout.
// Pure declarations; no latency or flow control of its own.
package core_timer_pkg;

    localparam int TMR_ADDR_W = 5;

    // Byte offsets of the timer register window (only bits [4:2] decode)
    localparam logic [4:0] TMR_MTIME_LO    = 5'h00;
    localparam logic [4:0] TMR_MTIME_HI    = 5'h04;
    localparam logic [4:0] TMR_MTIMECMP_LO = 5'h08;
    localparam logic [4:0] TMR_MTIMECMP_HI = 5'h0C;
    localparam logic [4:0] TMR_CTRL        = 5'h10;

    // mtimecmp powers up at its maximum so the interrupt stays quiet
    localparam logic [63:0] TMR_MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

    // ctrl register layout
    localparam int TMR_CTRL_EN_BIT  = 0;
    localparam int TMR_CTRL_DIV_LSB = 8;

endpackage

// File: rtl/core_timer_if.sv
// Single-cycle register port of the machine timer (requester = master).
// Latency: tmr_ready/tmr_rdata one cycle after tmr_sel.
// Backpressure: none; the timer accepts a request every cycle.
// Signals: tmr_sel (request pulse), tmr_wr (1 = write), tmr_addr (byte
// address), tmr_wdata, tmr_rdata (registered), tmr_ready (done pulse).
interface core_timer_if
    import core_timer_pkg::*;
#(
    parameter int ADDR_W = TMR_ADDR_W
);
    logic              tmr_sel;
    logic              tmr_wr;
    logic [ADDR_W-1:0] tmr_addr;
    logic [31:0]       tmr_wdata;
    logic [31:0]       tmr_rdata;
    logic              tmr_ready;

    modport master (
        output tmr_sel, tmr_wr, tmr_addr, tmr_wdata,
        input  tmr_rdata, tmr_ready
    );

    modport slave (
        input  tmr_sel, tmr_wr, tmr_addr, tmr_wdata,
        output tmr_rdata, tmr_ready
    );

endinterface

// File: rtl/core_timer_prescaler.sv
// Prescaler for the machine timer: one tick every div+1 enabled cycles.
// Latency: tick is combinational from the count; count updates each edge.
// Backpressure: none. Only built when KRV_TIMER_PRESCALE_EN is defined.
// Ports: cpu_clk, cpu_rst (async, active-high), en, div, clr -> tick.
`ifdef KRV_TIMER_PRESCALE_EN
module timer_prescaler
    import core_timer_pkg::*;
#(
    parameter int PRESCALE_W = 8
) (
    input  logic                  cpu_clk,
    input  logic                  cpu_rst,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] div,
    input  logic                  clr,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt;

    assign tick = en && (cnt == div);

    // Count restarts when disabled, when ctrl is rewritten, or after a tick
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            cnt <= '0;
        end else if (!en || clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/core_timer.sv
// Machine timer: 64-bit mtime/mtimecmp with a level interrupt timer_int.
// Latency: register access completes 1 cycle after tmr_sel; timer_int
// follows the compare 1 cycle late. Backpressure: none, zero wait states.
// Ports: cpu_clk, cpu_rst (async, active-high), bus (core_timer_if.slave),
// timer_int. Option: KRV_TIMER_PRESCALE_EN adds a div prescaler on tick.
module core_timer
    import core_timer_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int PRESCALE_W = 8
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    core_timer_if.slave   bus,
    output logic          timer_int
);

    logic [63:0]       mtime;
    logic [63:0]       mtimecmp;
    logic [31:0]       hi_shadow;
    logic              ctrl_en;
    logic              tick;
    logic [31:0]       ctrl_rdata;
    logic [ADDR_W-1:0] acc_addr;
    logic [4:0]        reg_off;
    logic              unused_addr;
    logic              rd_acc;
    logic              wr_acc;
    logic              wr_mtime_lo;
    logic              wr_mtime_hi;
    logic              wr_ctrl;

    assign acc_addr    = bus.tmr_addr;
    assign reg_off     = {acc_addr[4:2], 2'b00};
    assign unused_addr = ^acc_addr[1:0];

    assign rd_acc      = bus.tmr_sel && !bus.tmr_wr;
    assign wr_acc      = bus.tmr_sel &&  bus.tmr_wr;
    assign wr_mtime_lo = wr_acc && (reg_off == TMR_MTIME_LO);
    assign wr_mtime_hi = wr_acc && (reg_off == TMR_MTIME_HI);
    assign wr_ctrl     = wr_acc && (reg_off == TMR_CTRL);

`ifdef KRV_TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] ctrl_div;

    timer_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .cpu_clk (cpu_clk),
        .cpu_rst (cpu_rst),
        .en      (ctrl_en),
        .div     (ctrl_div),
        .clr     (wr_ctrl),
        .tick    (tick)
    );
`else
    assign tick = ctrl_en;
`endif

    always_comb begin
        ctrl_rdata = '0;
        ctrl_rdata[TMR_CTRL_EN_BIT] = ctrl_en;
`ifdef KRV_TIMER_PRESCALE_EN
        ctrl_rdata[TMR_CTRL_DIV_LSB +: PRESCALE_W] = ctrl_div;
`else
        ctrl_rdata[TMR_CTRL_DIV_LSB +: PRESCALE_W] = '0;
`endif
    end

    // mtime: a software write to either half beats the increment and
    // leaves the other half (and any carry) untouched for that cycle.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            mtime <= '0;
        end else if (wr_mtime_lo) begin
            mtime[31:0] <= bus.tmr_wdata;
        end else if (wr_mtime_hi) begin
            mtime[63:32] <= bus.tmr_wdata;
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            mtimecmp <= TMR_MTIMECMP_RST;
        end else if (wr_acc && (reg_off == TMR_MTIMECMP_LO)) begin
            mtimecmp[31:0] <= bus.tmr_wdata;
        end else if (wr_acc && (reg_off == TMR_MTIMECMP_HI)) begin
            mtimecmp[63:32] <= bus.tmr_wdata;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            ctrl_en  <= 1'b0;
`ifdef KRV_TIMER_PRESCALE_EN
            ctrl_div <= '0;
`endif
        end else if (wr_ctrl) begin
            ctrl_en  <= bus.tmr_wdata[TMR_CTRL_EN_BIT];
`ifdef KRV_TIMER_PRESCALE_EN
            ctrl_div <= bus.tmr_wdata[TMR_CTRL_DIV_LSB +: PRESCALE_W];
`endif
        end
    end

    // Reading mtime_lo snapshots mtime_hi so a lo-then-hi read pair is
    // coherent even if the low half wraps between the two accesses.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            hi_shadow <= '0;
        end else if (rd_acc && (reg_off == TMR_MTIME_LO)) begin
            hi_shadow <= mtime[63:32];
        end else if (wr_mtime_hi) begin
            hi_shadow <= bus.tmr_wdata;
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            bus.tmr_ready <= 1'b0;
            bus.tmr_rdata <= '0;
        end else begin
            bus.tmr_ready <= bus.tmr_sel;
            if (rd_acc) begin
                case (reg_off)
                    TMR_MTIME_LO:    bus.tmr_rdata <= mtime[31:0];
                    TMR_MTIME_HI:    bus.tmr_rdata <= hi_shadow;
                    TMR_MTIMECMP_LO: bus.tmr_rdata <= mtimecmp[31:0];
                    TMR_MTIMECMP_HI: bus.tmr_rdata <= mtimecmp[63:32];
                    TMR_CTRL:        bus.tmr_rdata <= ctrl_rdata;
                    default:         bus.tmr_rdata <= '0;
                endcase
            end
        end
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            timer_int <= 1'b0;
        end else begin
            timer_int <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_core_timer.sv
// Self-checking bench for core_timer: directed register accesses with
// literal expectations plus a per-cycle comparison against a behavioural
// model of the timer. Works with or without KRV_TIMER_PRESCALE_EN.
module tb_core_timer;
    import core_timer_pkg::*;

    logic cpu_clk = 1'b0;
    logic cpu_rst = 1'b1;
    logic timer_int;

    int n_tests = 0;
    int n_fail  = 0;

    core_timer_if #(.ADDR_W(5)) tif ();

    core_timer #(.ADDR_W(5), .PRESCALE_W(8)) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst   (cpu_rst),
        .bus       (tif.slave),
        .timer_int (timer_int)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: timer state as plain 64-bit numbers; the
    // prescaler is "every (div+1)-th enabled cycle since the last clear".
    // ------------------------------------------------------------------
    logic [63:0] m_mtime  = 64'd0;
    logic [63:0] m_cmp    = 64'hFFFF_FFFF_FFFF_FFFF;
    logic [31:0] m_shadow = 32'd0;
    logic [31:0] m_rdata  = 32'd0;
    logic        m_ready  = 1'b0;
    logic        m_int    = 1'b0;
    logic        m_en     = 1'b0;
    int          m_div    = 0;
    int          m_k      = 0;
    logic [4:0]  m_off;
    logic [31:0] m_wd;
    logic        m_rd, m_wr, m_tick;

    always @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            m_mtime = 64'd0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_shadow = 32'd0;
            m_rdata = 32'd0; m_ready = 1'b0; m_int = 1'b0; m_en = 1'b0;
            m_div = 0; m_k = 0;
        end else begin
            m_off = {tif.tmr_addr[4:2], 2'b00};
            m_rd  = tif.tmr_sel && !tif.tmr_wr;
            m_wr  = tif.tmr_sel &&  tif.tmr_wr;
            m_wd  = tif.tmr_wdata;
`ifdef KRV_TIMER_PRESCALE_EN
            m_tick = m_en && ((m_k % (m_div + 1)) == m_div);
`else
            m_tick = m_en;
`endif
            // Outputs for next cycle, from present state
            m_int   = (m_mtime >= m_cmp);
            m_ready = tif.tmr_sel;
            if (m_rd) begin
                case (m_off)
                    TMR_MTIME_LO: begin
                        m_rdata  = m_mtime[31:0];
                        m_shadow = m_mtime[63:32];
                    end
                    TMR_MTIME_HI:    m_rdata = m_shadow;
                    TMR_MTIMECMP_LO: m_rdata = m_cmp[31:0];
                    TMR_MTIMECMP_HI: m_rdata = m_cmp[63:32];
`ifdef KRV_TIMER_PRESCALE_EN
                    TMR_CTRL:        m_rdata = 32'(m_en) | (32'(m_div) << 8);
`else
                    TMR_CTRL:        m_rdata = 32'(m_en);
`endif
                    default:         m_rdata = 32'd0;
                endcase
            end
            // Prescaler phase counter
            if (!m_en || (m_wr && m_off == TMR_CTRL)) m_k = 0;
            else m_k = m_k + 1;
            // Increment only when software leaves mtime alone this cycle
            if (m_tick && !(m_wr && (m_off == TMR_MTIME_LO || m_off == TMR_MTIME_HI)))
                m_mtime = m_mtime + 64'd1;
            if (m_wr) begin
                case (m_off)
                    TMR_MTIME_LO:    m_mtime[31:0] = m_wd;
                    TMR_MTIME_HI: begin
                        m_mtime[63:32] = m_wd;
                        m_shadow = m_wd;
                    end
                    TMR_MTIMECMP_LO: m_cmp[31:0]  = m_wd;
                    TMR_MTIMECMP_HI: m_cmp[63:32] = m_wd;
                    TMR_CTRL: begin
                        m_en = m_wd[0];
`ifdef KRV_TIMER_PRESCALE_EN
                        m_div = int'(m_wd[15:8]);
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

    // One compare process: outputs are meaningful on every cycle
    always @(negedge cpu_clk) begin
        chk("cyc_ready", 64'(tif.tmr_ready), 64'(m_ready));
        chk("cyc_rdata", 64'(tif.tmr_rdata), 64'(m_rdata));
        chk("cyc_timer_int", 64'(timer_int), 64'(m_int));
    end

    // Called at posedge+1; returns at posedge+1 of the completion cycle
    task automatic acc(input logic wr, input logic [4:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd);
        tif.tmr_sel   = 1'b1;
        tif.tmr_wr    = wr;
        tif.tmr_addr  = addr;
        tif.tmr_wdata = wd;
        @(posedge cpu_clk);
        #1;
        tif.tmr_sel   = 1'b0;
        tif.tmr_wr    = 1'b0;
        rd = tif.tmr_rdata;
    endtask

    task automatic wr32(input logic [4:0] addr, input logic [31:0] wd);
        logic [31:0] dummy;
        acc(1'b1, addr, wd, dummy);
    endtask

    task automatic next_cyc();
        @(posedge cpu_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, required finish before timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        tif.tmr_sel = 1'b0; tif.tmr_wr = 1'b0; tif.tmr_addr = '0; tif.tmr_wdata = '0;
        #22 cpu_rst = 1'b0;
        next_cyc();

        // Reset values through the register port
        chk("rst_timer_int", 64'(timer_int), 64'd0);
        acc(1'b0, TMR_MTIME_LO, 0, rd);    chk("rst_mtime_lo", 64'(rd), 64'd0);
        acc(1'b0, TMR_MTIME_HI, 0, rd);    chk("rst_mtime_hi", 64'(rd), 64'd0);
        acc(1'b0, TMR_MTIMECMP_LO, 0, rd); chk("rst_cmp_lo", 64'(rd), 64'hFFFF_FFFF);
        acc(1'b0, TMR_MTIMECMP_HI, 0, rd); chk("rst_cmp_hi", 64'(rd), 64'hFFFF_FFFF);
        acc(1'b0, TMR_CTRL, 0, rd);        chk("rst_ctrl", 64'(rd), 64'd0);
        wr32(5'h14, 32'hDEAD_BEEF);
        acc(1'b0, 5'h14, 0, rd);           chk("unmapped_read", 64'(rd), 64'd0);

        // Carry from lo into hi: 0x0_FFFFFFFE + 2 ticks
        wr32(TMR_MTIME_LO, 32'hFFFF_FFFE);
        wr32(TMR_MTIME_HI, 32'h0);
        wr32(TMR_CTRL, 32'h1);
        next_cyc();
        wr32(TMR_CTRL, 32'h0);
        acc(1'b0, TMR_MTIME_LO, 0, rd); chk("carry_lo", 64'(rd), 64'h0);
        acc(1'b0, TMR_MTIME_HI, 0, rd); chk("carry_hi", 64'(rd), 64'h1);

        // Lo-then-hi read straddling the wrap stays coherent
        wr32(TMR_MTIME_LO, 32'hFFFF_FFFF);
        wr32(TMR_MTIME_HI, 32'h0);
        wr32(TMR_CTRL, 32'h1);
        acc(1'b0, TMR_MTIME_LO, 0, rd); chk("atomic_lo", 64'(rd), 64'hFFFF_FFFF);
        acc(1'b0, TMR_MTIME_HI, 0, rd); chk("atomic_hi", 64'(rd), 64'h0);
        wr32(TMR_CTRL, 32'h0);
        acc(1'b0, TMR_MTIME_LO, 0, rd); chk("after_wrap_lo", 64'(rd), 64'h2);
        acc(1'b0, TMR_MTIME_HI, 0, rd); chk("after_wrap_hi", 64'(rd), 64'h1);

        // Interrupt rise/fall latency, mtimecmp = 10
        wr32(TMR_MTIME_HI, 32'h0);
        wr32(TMR_MTIME_LO, 32'h0);
        wr32(TMR_MTIMECMP_HI, 32'h0);
        wr32(TMR_MTIMECMP_LO, 32'd10);
        wr32(TMR_CTRL, 32'h1);
        repeat (10) next_cyc();
        chk("int_before_rise", 64'(timer_int), 64'd0);
        next_cyc();
        chk("int_rise", 64'(timer_int), 64'd1);
        wr32(TMR_MTIMECMP_LO, 32'd100);
        chk("int_hold_after_cmp_wr", 64'(timer_int), 64'd1);
        next_cyc();
        chk("int_fall", 64'(timer_int), 64'd0);
        wr32(TMR_CTRL, 32'h0);

        // Write to mtime_lo collides with a tick
        wr32(TMR_MTIME_HI, 32'h5);
        wr32(TMR_CTRL, 32'h1);
        wr32(TMR_MTIME_LO, 32'h1234);
        wr32(TMR_CTRL, 32'h0);
        acc(1'b0, TMR_MTIME_LO, 0, rd); chk("wr_lo_vs_tick_lo", 64'(rd), 64'h1235);
        acc(1'b0, TMR_MTIME_HI, 0, rd); chk("wr_lo_vs_tick_hi", 64'(rd), 64'h5);

        // Write to mtime_hi collides with a tick that would carry
        wr32(TMR_MTIME_LO, 32'hFFFF_FFFF);
        wr32(TMR_MTIME_HI, 32'h7);
        wr32(TMR_CTRL, 32'h1);
        wr32(TMR_MTIME_HI, 32'h9);
        wr32(TMR_CTRL, 32'h0);
        acc(1'b0, TMR_MTIME_LO, 0, rd); chk("wr_hi_vs_tick_lo", 64'(rd), 64'h0);
        acc(1'b0, TMR_MTIME_HI, 0, rd); chk("wr_hi_vs_tick_hi", 64'(rd), 64'hA);

        // Prescaler: div=3, enabled for 40 cycles
        wr32(TMR_MTIME_HI, 32'h0);
        wr32(TMR_MTIME_LO, 32'h0);
        wr32(TMR_CTRL, 32'h0000_0301);
        acc(1'b0, TMR_CTRL, 0, rd);
`ifdef KRV_TIMER_PRESCALE_EN
        chk("ctrl_div_read", 64'(rd), 64'h301);
`else
        chk("ctrl_div_read", 64'(rd), 64'h1);
`endif
        repeat (38) next_cyc();
        wr32(TMR_CTRL, 32'h0);
        acc(1'b0, TMR_MTIME_LO, 0, rd);
`ifdef KRV_TIMER_PRESCALE_EN
        chk("prescale_mtime", 64'(rd), 64'd10);
`else
        chk("prescale_mtime", 64'(rd), 64'd40);
`endif

        // Reset while timer_int is high and a read has just completed
        wr32(TMR_MTIME_HI, 32'h1);
        repeat (2) next_cyc();
        chk("int_before_reset", 64'(timer_int), 64'd1);
        tif.tmr_sel = 1'b1; tif.tmr_wr = 1'b0; tif.tmr_addr = TMR_MTIME_LO;
        @(posedge cpu_clk);
        #1 tif.tmr_sel = 1'b0;
        chk("ready_before_reset", 64'(tif.tmr_ready), 64'd1);
        #2 cpu_rst = 1'b1;
        #1;
        chk("rst_async_ready", 64'(tif.tmr_ready), 64'd0);
        chk("rst_async_int", 64'(timer_int), 64'd0);
        chk("rst_async_rdata", 64'(tif.tmr_rdata), 64'd0);
        @(posedge cpu_clk);
        #4 cpu_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            chk("no_ready_after_reset", 64'(tif.tmr_ready), 64'd0);
        end
        acc(1'b0, TMR_MTIME_LO, 0, rd);    chk("post_rst_mtime_lo", 64'(rd), 64'd0);
        acc(1'b0, TMR_MTIME_HI, 0, rd);    chk("post_rst_mtime_hi", 64'(rd), 64'd0);
        acc(1'b0, TMR_MTIMECMP_HI, 0, rd); chk("post_rst_cmp_hi", 64'(rd), 64'hFFFF_FFFF);
        acc(1'b0, TMR_CTRL, 0, rd);        chk("post_rst_ctrl", 64'(rd), 64'd0);
        repeat (2) next_cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
